// File: rtl/regfile_sec_pkg.sv
// Shared types and defaults for the secured register file initiator.
package regfile_sec_pkg;
  localparam int DEF_AW        = 10;
  localparam int DEF_DW        = 32;
  localparam int DEF_SINK_ADDR = 1023;
  localparam int KEY_W         = 16;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } sec_state_e;
endpackage

// File: rtl/regfile_unlock_fsm.sv
// Key unlock state machine with brute-force lockout and idle auto-relock.
// Transitions take effect the cycle after the triggering input; no backpressure.
module regfile_unlock_fsm
  import regfile_sec_pkg::*;
#(
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 256,
  parameter int UNLOCK_TIMEOUT = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_unlock_valid,
  input  logic       i_key_match,
  input  logic       i_relock,
  input  logic       i_prot_access,
  output sec_state_e o_state,
  output logic       o_locked,
  output logic       o_lockout
);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int IW = $clog2(UNLOCK_TIMEOUT);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST = IW'(UNLOCK_TIMEOUT - 1);

  sec_state_e    r_state;
  logic [FW-1:0] r_fail_cnt;
  logic [LW-1:0] r_lock_tmr;
  logic [IW-1:0] r_idle_tmr;
  logic          r_locked;
  logic          r_lockout;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_LOCKED;
      r_fail_cnt <= '0;
      r_lock_tmr <= '0;
      r_idle_tmr <= '0;
      r_locked   <= 1'b1;
      r_lockout  <= 1'b0;
    end else begin
      case (r_state)
        ST_LOCKED: begin
          if (i_unlock_valid) begin
            if (i_key_match) begin
              r_state    <= ST_UNLOCKED;
              r_fail_cnt <= '0;
              r_idle_tmr <= '0;
              r_locked   <= 1'b0;
            end else if (r_fail_cnt == FAIL_LAST) begin
              r_state    <= ST_LOCKOUT;
              r_fail_cnt <= r_fail_cnt + 1'b1;
              r_lock_tmr <= LOCK_LOAD;
              r_lockout  <= 1'b1;
            end else begin
              r_fail_cnt <= r_fail_cnt + 1'b1;
            end
          end
        end
        ST_LOCKOUT: begin
          // Attempts are ignored here; the last timer cycle hands back to LOCKED.
          if (r_lock_tmr == LW'(1)) begin
            r_state    <= ST_LOCKED;
            r_fail_cnt <= '0;
            r_lock_tmr <= '0;
            r_lockout  <= 1'b0;
          end else begin
            r_lock_tmr <= r_lock_tmr - 1'b1;
          end
        end
        ST_UNLOCKED: begin
          if (i_relock || (!i_prot_access && (r_idle_tmr == IDLE_LAST))) begin
            r_state    <= ST_LOCKED;
            r_idle_tmr <= '0;
            r_locked   <= 1'b1;
          end else if (i_prot_access) begin
            r_idle_tmr <= '0;
          end else begin
            r_idle_tmr <= r_idle_tmr + 1'b1;
          end
        end
        default: begin
          r_state   <= ST_LOCKED;
          r_locked  <= 1'b1;
          r_lockout <= 1'b0;
        end
      endcase
    end
  end

  assign o_state   = r_state;
  assign o_locked  = r_locked;
  assign o_lockout = r_lockout;
endmodule

// File: rtl/regfile_access_ctrl.sv
// Secured regfile initiator: gates the protected region, forwards same-cycle writes, 1-cycle read response.
// No backpressure; writes issue every cycle. Optional SEC_AUDIT_EN adds violation count/last address.
module regfile_access_ctrl
  import regfile_sec_pkg::*;
#(
  parameter int AW             = DEF_AW,
  parameter int DW             = DEF_DW,
  parameter int PROT_BASE      = 992,
  parameter int SINK_ADDR      = DEF_SINK_ADDR,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 256,
  parameter int UNLOCK_TIMEOUT = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rd_valid,
  input  logic [AW-1:0]    i_rd_addr1,
  input  logic [AW-1:0]    i_rd_addr2,
  output logic             o_rsp_valid,
  output logic [DW-1:0]    o_rsp_data1,
  output logic [DW-1:0]    o_rsp_data2,
  input  logic             i_wb_alu_valid,
  input  logic [AW-1:0]    i_wb_alu_addr,
  input  logic [DW-1:0]    i_wb_alu_data,
  input  logic             i_wb_mem_valid,
  input  logic [AW-1:0]    i_wb_mem_addr,
  input  logic [DW-1:0]    i_wb_mem_data,
  input  logic             i_unlock_valid,
  input  logic [KEY_W-1:0] i_unlock_key,
  input  logic             i_relock,
  output logic             o_locked,
  output logic             o_lockout,
  output logic             o_violation,
`ifdef SEC_AUDIT_EN
  output logic [15:0]      o_viol_count,
  output logic [AW-1:0]    o_last_viol_addr,
`endif
  output logic [AW-1:0]    o_rf_reg1,
  output logic [AW-1:0]    o_rf_reg2,
  output logic [AW-1:0]    o_rf_address_alu,
  output logic [AW-1:0]    o_rf_address_mem,
  output logic [DW-1:0]    o_rf_write_data_alu,
  output logic [DW-1:0]    o_rf_write_data_mem,
  input  logic [DW-1:0]    i_rf_read_reg1,
  input  logic [DW-1:0]    i_rf_read_reg2,
  input  logic [KEY_W-1:0] i_rf_key_access
);
  localparam logic [AW-1:0] SINK    = AW'(SINK_ADDR);
  localparam logic [AW-1:0] PROT_LO = AW'(PROT_BASE);

  sec_state_e    w_state;
  logic          w_unlocked;
  logic          w_alu_live, w_alu_prot, w_alu_ok;
  logic          w_mem_live, w_mem_prot, w_mem_ok;
  logic          w_rd1_prot, w_rd2_prot;
  logic          w_viol, w_prot_access;
  logic [DW-1:0] w_rd_dat1, w_rd_dat2;
  logic          r_rsp_valid, r_violation;
  logic [DW-1:0] r_rsp_data1, r_rsp_data2;

  function automatic logic is_prot(input logic [AW-1:0] a);
    return (a >= PROT_LO) && (a != SINK);
  endfunction

  // ALU is applied after MEM so it wins on an address collision, like the regfile.
  function automatic logic [DW-1:0] read_val(
    input logic [AW-1:0] a, input logic [DW-1:0] rf, input logic unl,
    input logic alu_ok, input logic [AW-1:0] alu_a, input logic [DW-1:0] alu_d,
    input logic mem_ok, input logic [AW-1:0] mem_a, input logic [DW-1:0] mem_d);
    logic [DW-1:0] v;
    v = rf;
    if (mem_ok && (mem_a == a)) v = mem_d;
    if (alu_ok && (alu_a == a)) v = alu_d;
    if ((a == SINK) || (is_prot(a) && !unl)) v = '0;
    return v;
  endfunction

  assign w_unlocked = (w_state == ST_UNLOCKED);
  assign w_alu_live = i_wb_alu_valid && (i_wb_alu_addr != SINK);
  assign w_mem_live = i_wb_mem_valid && (i_wb_mem_addr != SINK);
  assign w_alu_prot = w_alu_live && is_prot(i_wb_alu_addr);
  assign w_mem_prot = w_mem_live && is_prot(i_wb_mem_addr);
  assign w_alu_ok   = !i_rst && w_alu_live && (!w_alu_prot || w_unlocked);
  assign w_mem_ok   = !i_rst && w_mem_live && (!w_mem_prot || w_unlocked);
  assign w_rd1_prot = i_rd_valid && is_prot(i_rd_addr1);
  assign w_rd2_prot = i_rd_valid && is_prot(i_rd_addr2);

  assign w_prot_access = w_alu_prot || w_mem_prot || w_rd1_prot || w_rd2_prot;
  assign w_viol        = w_prot_access && !w_unlocked;

  assign o_rf_address_alu    = w_alu_ok ? i_wb_alu_addr : SINK;
  assign o_rf_address_mem    = w_mem_ok ? i_wb_mem_addr : SINK;
  assign o_rf_write_data_alu = w_alu_ok ? i_wb_alu_data : '0;
  assign o_rf_write_data_mem = w_mem_ok ? i_wb_mem_data : '0;
  assign o_rf_reg1           = (!i_rst && i_rd_valid) ? i_rd_addr1 : '0;
  assign o_rf_reg2           = (!i_rst && i_rd_valid) ? i_rd_addr2 : '0;

  assign w_rd_dat1 = read_val(i_rd_addr1, i_rf_read_reg1, w_unlocked,
                              w_alu_ok, i_wb_alu_addr, i_wb_alu_data,
                              w_mem_ok, i_wb_mem_addr, i_wb_mem_data);
  assign w_rd_dat2 = read_val(i_rd_addr2, i_rf_read_reg2, w_unlocked,
                              w_alu_ok, i_wb_alu_addr, i_wb_alu_data,
                              w_mem_ok, i_wb_mem_addr, i_wb_mem_data);

  regfile_unlock_fsm #(
    .MAX_FAIL       (MAX_FAIL),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .UNLOCK_TIMEOUT (UNLOCK_TIMEOUT)
  ) u_fsm (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_unlock_valid (i_unlock_valid),
    .i_key_match    (i_unlock_key == i_rf_key_access),
    .i_relock       (i_relock),
    .i_prot_access  (w_prot_access),
    .o_state        (w_state),
    .o_locked       (o_locked),
    .o_lockout      (o_lockout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data1 <= '0;
      r_rsp_data2 <= '0;
      r_violation <= 1'b0;
    end else begin
      r_rsp_valid <= i_rd_valid;
      r_violation <= w_viol;
      if (i_rd_valid) begin
        r_rsp_data1 <= w_rd_dat1;
        r_rsp_data2 <= w_rd_dat2;
      end
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data1 = r_rsp_data1;
  assign o_rsp_data2 = r_rsp_data2;
  assign o_violation = r_violation;

`ifdef SEC_AUDIT_EN
  logic [15:0]   r_viol_count;
  logic [AW-1:0] r_last_viol_addr;
  logic [AW-1:0] w_viol_addr;

  always_comb begin
    w_viol_addr = i_rd_addr2;
    if (w_rd1_prot)      w_viol_addr = i_rd_addr1;
    else if (w_rd2_prot) w_viol_addr = i_rd_addr2;
    if (w_mem_prot)      w_viol_addr = i_wb_mem_addr;
    if (w_alu_prot)      w_viol_addr = i_wb_alu_addr;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_viol_count     <= '0;
      r_last_viol_addr <= '0;
    end else if (w_viol) begin
      if (r_viol_count != 16'hFFFF) r_viol_count <= r_viol_count + 16'd1;
      r_last_viol_addr <= w_viol_addr;
    end
  end

  assign o_viol_count     = r_viol_count;
  assign o_last_viol_addr = r_last_viol_addr;
`endif
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: directed vectors, FSM corner sequences, randomized run vs reference model.
module tb_regfile_access_ctrl;
  localparam logic [15:0] KEY  = 16'h0032;
  localparam logic [9:0]  SINK = 10'd1023;

  logic        clk;
  logic        rst;
  logic        rd_valid;
  logic [9:0]  rd_addr1, rd_addr2;
  logic        rsp_valid;
  logic [31:0] rsp_data1, rsp_data2;
  logic        alu_v, mem_v;
  logic [9:0]  alu_a, mem_a;
  logic [31:0] alu_d, mem_d;
  logic        unlock_valid, relock;
  logic [15:0] unlock_key, rf_key;
  logic        locked, lockout, violation;
  logic [9:0]  rf_reg1, rf_reg2, rf_addr_alu, rf_addr_mem;
  logic [31:0] rf_wd_alu, rf_wd_mem, rf_rd1, rf_rd2;
`ifdef SEC_AUDIT_EN
  logic [15:0] viol_count;
  logic [9:0]  last_viol_addr;
`endif

  logic [31:0] rf_mem [0:1023];
  logic [31:0] shadow [0:1023];
  int n_checks = 0;
  int n_pass   = 0;

  regfile_access_ctrl dut (
    .i_clk(clk), .i_rst(rst),
    .i_rd_valid(rd_valid), .i_rd_addr1(rd_addr1), .i_rd_addr2(rd_addr2),
    .o_rsp_valid(rsp_valid), .o_rsp_data1(rsp_data1), .o_rsp_data2(rsp_data2),
    .i_wb_alu_valid(alu_v), .i_wb_alu_addr(alu_a), .i_wb_alu_data(alu_d),
    .i_wb_mem_valid(mem_v), .i_wb_mem_addr(mem_a), .i_wb_mem_data(mem_d),
    .i_unlock_valid(unlock_valid), .i_unlock_key(unlock_key), .i_relock(relock),
    .o_locked(locked), .o_lockout(lockout), .o_violation(violation),
`ifdef SEC_AUDIT_EN
    .o_viol_count(viol_count), .o_last_viol_addr(last_viol_addr),
`endif
    .o_rf_reg1(rf_reg1), .o_rf_reg2(rf_reg2),
    .o_rf_address_alu(rf_addr_alu), .o_rf_address_mem(rf_addr_mem),
    .o_rf_write_data_alu(rf_wd_alu), .o_rf_write_data_mem(rf_wd_mem),
    .i_rf_read_reg1(rf_rd1), .i_rf_read_reg2(rf_rd2),
    .i_rf_key_access(rf_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile model: combinational read, last-write-wins with ALU written last.
  always @(posedge clk) begin
    rf_mem[rf_addr_mem] <= rf_wd_mem;
    rf_mem[rf_addr_alu] <= rf_wd_alu;
  end
  assign rf_rd1 = rf_mem[rf_reg1];
  assign rf_rd2 = rf_mem[rf_reg2];

  typedef struct {
    logic        alu_v; logic [9:0] alu_a; logic [31:0] alu_d;
    logic        mem_v; logic [9:0] mem_a; logic [31:0] mem_d;
    logic        rd_v;  logic [9:0] a1;    logic [9:0]  a2;
    logic [9:0]  x_alu_a; logic [9:0] x_mem_a;
    logic        x_viol;  logic       x_rv;
    logic [31:0] x_d1;    logic [31:0] x_d2;
  } vec_t;

  function automatic vec_t mk(int av, int aa, int ad, int mv, int ma, int md,
                              int rv, int r1, int r2, int xa, int xm,
                              int xv, int xr, int xd1, int xd2);
    vec_t v;
    v.alu_v = av[0]; v.alu_a = aa[9:0]; v.alu_d = ad;
    v.mem_v = mv[0]; v.mem_a = ma[9:0]; v.mem_d = md;
    v.rd_v  = rv[0]; v.a1 = r1[9:0]; v.a2 = r2[9:0];
    v.x_alu_a = xa[9:0]; v.x_mem_a = xm[9:0];
    v.x_viol = xv[0]; v.x_rv = xr[0]; v.x_d1 = xd1; v.x_d2 = xd2;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_valid = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
    alu_v = 1'b0; alu_a = '0; alu_d = '0;
    mem_v = 1'b0; mem_a = '0; mem_d = '0;
    unlock_valid = 1'b0; unlock_key = '0; relock = 1'b0;
  endtask

  function automatic logic [9:0] pick();
    int s;
    s = $urandom_range(0, 7);
    if (s < 4)  return 10'($urandom_range(0, 7));
    if (s < 7)  return 10'($urandom_range(992, 999));
    return SINK;
  endfunction

  function automatic bit prot(input logic [9:0] a);
    return (a >= 10'd992) && (a != SINK);
  endfunction

  vec_t vt[13];
  int   cnt;
  int   m_mode, m_fails, m_last, m_lock_end;
  bit   unl, a_ok, m_ok, pacc, xviol;
  logic [31:0] x1, x2;

  initial begin
    for (int i = 0; i < 1024; i++) rf_mem[i] = '0;
    idle_inputs();
    rf_key = KEY;
    rst = 1'b1;
    // Requests presented during reset must not reach the regfile ports.
    alu_v = 1'b1; alu_a = 10'd5; alu_d = 32'd77;
    rd_valid = 1'b1; rd_addr1 = 10'd3; rd_addr2 = 10'd4;
    tick(); tick();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data1", rsp_data1, 32'd0);
    check("rst_violation", 32'(violation), 32'd0);
    check("rst_locked", 32'(locked), 32'd1);
    check("rst_lockout", 32'(lockout), 32'd0);
    check("rst_rf_addr_alu", 32'(rf_addr_alu), 32'(SINK));
    check("rst_rf_addr_mem", 32'(rf_addr_mem), 32'(SINK));
    check("rst_rf_wdata_alu", rf_wd_alu, 32'd0);
    check("rst_rf_reg1", 32'(rf_reg1), 32'd0);
    rst = 1'b0;
    idle_inputs();

    vt[0]  = mk(1, 4, 9,     0, 0, 0,     1, 4, 5,      4, 1023,    0, 1, 9, 0);
    vt[1]  = mk(1, 6, 11,    1, 6, 22,    0, 0, 0,      6, 6,       0, 0, 0, 0);
    vt[2]  = mk(0, 0, 0,     0, 0, 0,     1, 6, 4,      1023, 1023, 0, 1, 11, 9);
    vt[3]  = mk(1, 1000, 7,  0, 0, 0,     0, 0, 0,      1023, 1023, 1, 0, 0, 0);
    vt[4]  = mk(0, 0, 0,     0, 0, 0,     1, 1000, 4,   1023, 1023, 1, 1, 0, 9);
    vt[5]  = mk(0, 0, 0,     1, 1023, 5,  0, 0, 0,      1023, 1023, 0, 0, 0, 0);
    vt[6]  = mk(0, 0, 0,     0, 0, 0,     1, 1023, 6,   1023, 1023, 0, 1, 0, 11);
    vt[7]  = mk(0, 0, 0,     0, 0, 0,     0, 0, 0,      1023, 1023, 0, 0, 0, 0);
    vt[8]  = mk(0, 0, 0,     1, 7, 33,    1, 7, 6,      1023, 7,    0, 1, 33, 11);
    vt[9]  = mk(1, 8, 1,     1, 8, 2,     1, 8, 8,      8, 8,       0, 1, 1, 1);
    vt[10] = mk(1, 1023, 3,  1, 992, 4,   0, 0, 0,      1023, 1023, 1, 0, 0, 0);
    vt[11] = mk(0, 0, 0,     0, 0, 0,     1, 9, 995,    1023, 1023, 1, 1, 0, 0);
    vt[12] = mk(0, 0, 0,     0, 0, 0,     1, 8, 7,      1023, 1023, 0, 1, 1, 33);

    for (int i = 0; i < 13; i++) begin
      alu_v = vt[i].alu_v; alu_a = vt[i].alu_a; alu_d = vt[i].alu_d;
      mem_v = vt[i].mem_v; mem_a = vt[i].mem_a; mem_d = vt[i].mem_d;
      rd_valid = vt[i].rd_v; rd_addr1 = vt[i].a1; rd_addr2 = vt[i].a2;
      #1;
      check($sformatf("vec%0d_rf_addr_alu", i), 32'(rf_addr_alu), 32'(vt[i].x_alu_a));
      check($sformatf("vec%0d_rf_addr_mem", i), 32'(rf_addr_mem), 32'(vt[i].x_mem_a));
      tick();
      check($sformatf("vec%0d_violation", i), 32'(violation), 32'(vt[i].x_viol));
      check($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vt[i].x_rv));
      if (vt[i].x_rv) begin
        check($sformatf("vec%0d_rsp_data1", i), rsp_data1, vt[i].x_d1);
        check($sformatf("vec%0d_rsp_data2", i), rsp_data2, vt[i].x_d2);
      end
    end
    idle_inputs();

    // Unlock cycle itself is still locked: protected write is redirected.
    unlock_valid = 1'b1; unlock_key = KEY;
    alu_v = 1'b1; alu_a = 10'd993; alu_d = 32'd44;
    #1;
    check("unlock_cycle_alu_addr", 32'(rf_addr_alu), 32'(SINK));
    tick();
    check("unlock_locked", 32'(locked), 32'd0);
    check("unlock_cycle_violation", 32'(violation), 32'd1);
    idle_inputs();
    alu_v = 1'b1; alu_a = 10'd992; alu_d = 32'd5;
    #1;
    check("unlocked_prot_alu_addr", 32'(rf_addr_alu), 32'd992);
    tick();
    check("unlocked_write_no_viol", 32'(violation), 32'd0);
    idle_inputs();
    rd_valid = 1'b1; rd_addr1 = 10'd992; rd_addr2 = 10'd993;
    tick();
    check("unlocked_read_992", rsp_data1, 32'd5);
    check("unlocked_read_993", rsp_data2, 32'd0);
    idle_inputs();

    cnt = 0;
    while (locked == 1'b0 && cnt < 2000) begin
      cnt++;
      tick();
    end
    check("idle_unlocked_cycles", 32'(cnt), 32'd1024);
    check("idle_relocked", 32'(locked), 32'd1);

    unlock_valid = 1'b1; unlock_key = 16'h1234;
    tick(); check("wrong1_lockout", 32'(lockout), 32'd0);
    tick(); check("wrong2_lockout", 32'(lockout), 32'd0);
    tick(); check("wrong3_lockout", 32'(lockout), 32'd1);
    check("lockout_locked", 32'(locked), 32'd1);
    unlock_key = KEY;
    cnt = 0;
    while (lockout == 1'b1 && cnt < 1000) begin
      cnt++;
      if (locked != 1'b1) check("lockout_key_ignored", 32'(locked), 32'd1);
      tick();
    end
    check("lockout_cycles", 32'(cnt), 32'd256);
    check("after_lockout_locked", 32'(locked), 32'd1);
    tick();
    check("after_lockout_unlock", 32'(locked), 32'd0);
    relock = 1'b1;
    tick();
    check("relock_wins", 32'(locked), 32'd1);
    relock = 1'b0;
    tick();
    check("unlock_after_relock", 32'(locked), 32'd0);
    idle_inputs();
    rd_valid = 1'b1; rd_addr1 = 10'd4; rst = 1'b1;
    tick();
    check("rst_midread_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_midread_locked", 32'(locked), 32'd1);
    rst = 1'b0;
    idle_inputs();
    tick();

    // Reference model: mode 0 locked, 1 unlocked, 2 lockout; timers as cycle stamps.
    for (int i = 0; i < 1024; i++) shadow[i] = rf_mem[i];
    m_mode = 0; m_fails = 0; m_last = 0; m_lock_end = 0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      alu_v = 1'($urandom_range(0, 1)); alu_a = pick(); alu_d = $urandom;
      mem_v = 1'($urandom_range(0, 1)); mem_a = pick(); mem_d = $urandom;
      rd_valid = 1'($urandom_range(0, 1)); rd_addr1 = pick(); rd_addr2 = pick();
      unlock_valid = ($urandom_range(0, 7) == 0);
      unlock_key = ($urandom_range(0, 1) == 1) ? KEY : 16'($urandom);
      relock = ($urandom_range(0, 63) == 0);
      #1;
      unl  = (m_mode == 1);
      a_ok = !rst && alu_v && alu_a != SINK && (!prot(alu_a) || unl);
      m_ok = !rst && mem_v && mem_a != SINK && (!prot(mem_a) || unl);
      pacc = (alu_v && prot(alu_a)) || (mem_v && prot(mem_a)) ||
             (rd_valid && (prot(rd_addr1) || prot(rd_addr2)));
      xviol = !rst && pacc && !unl;
      check("rnd_rf_addr_alu", 32'(rf_addr_alu), a_ok ? 32'(alu_a) : 32'(SINK));
      check("rnd_rf_addr_mem", 32'(rf_addr_mem), m_ok ? 32'(mem_a) : 32'(SINK));
      if (m_ok) shadow[mem_a] = mem_d;
      if (a_ok) shadow[alu_a] = alu_d;
      x1 = (rd_addr1 == SINK || (prot(rd_addr1) && !unl)) ? 32'd0 : shadow[rd_addr1];
      x2 = (rd_addr2 == SINK || (prot(rd_addr2) && !unl)) ? 32'd0 : shadow[rd_addr2];
      if (rst) begin
        m_mode = 0; m_fails = 0;
      end else if (m_mode == 1) begin
        if (relock) m_mode = 0;
        else if (pacc) m_last = c;
        else if (c - m_last >= 1024) m_mode = 0;
      end else if (m_mode == 2) begin
        if (c >= m_lock_end) begin m_mode = 0; m_fails = 0; end
      end else if (unlock_valid) begin
        if (unlock_key == KEY) begin m_mode = 1; m_fails = 0; m_last = c; end
        else begin
          m_fails++;
          if (m_fails >= 3) begin m_mode = 2; m_lock_end = c + 256; end
        end
      end
      tick();
      check("rnd_rsp_valid", 32'(rsp_valid), 32'(!rst && rd_valid));
      if (!rst && rd_valid) begin
        check("rnd_rsp_data1", rsp_data1, x1);
        check("rnd_rsp_data2", rsp_data2, x2);
      end
      check("rnd_violation", 32'(violation), 32'(xviol));
      check("rnd_locked", 32'(locked), 32'(m_mode != 1));
      check("rnd_lockout", 32'(lockout), 32'(m_mode == 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
